// File: rtl/shift_rows_serial_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// shift_rows_serial_pkg -- shared AES column/byte constants and byte indexing
// Rev 1.0
// ------------------------------------------------------------------------
package shift_rows_serial_pkg;

  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = COL_W / BYTE_W;
  localparam int STATE_W  = COL_W * NUM_COLS;
  localparam int CNT_W    = 2;

  localparam logic [CNT_W-1:0] FIRST_COL = '0;
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    BANK_FILL  = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DRAIN = 2'd2
  } bank_state_e;

  // Flat byte position of (column, row) inside a column-major 128-bit state.
  function automatic int byte_idx(input int col, input int row);
    return col * NUM_ROWS + row;
  endfunction

  // Input column that supplies output column col at row row.
  function automatic int src_col(input int col, input int row, input logic inv);
    if (inv) begin
      return (col - row + NUM_COLS) % NUM_COLS;
    end
    return (col + row) % NUM_COLS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_bank.sv
`default_nettype none
// ------------------------------------------------------------------------
// shift_rows_bank -- one 128-bit state buffer with FILL/FULL/DRAIN control
// Rev 1.0  (inverse mapping with SHIFT_ROWS_SERIAL_INV_EN)
// ------------------------------------------------------------------------
module shift_rows_bank
  import shift_rows_serial_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_data,
`ifdef SHIFT_ROWS_SERIAL_INV_EN
  input  logic             wr_inv,
`endif
  input  logic             rd_en,
  output logic             is_fill,
  output logic             has_data,
  output logic             wr_last,
  output logic             rd_last,
  output logic [COL_W-1:0] rd_data
);

  bank_state_e        state_q, state_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [STATE_W-1:0] buf_q, buf_d;
  logic               sel_inv;

`ifdef SHIFT_ROWS_SERIAL_INV_EN
  logic inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (wr_en && (state_q == BANK_FILL) && (fill_cnt_q == FIRST_COL)) begin
      inv_d = wr_inv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign sel_inv = inv_q;
`else
  assign sel_inv = 1'b0;
`endif

  // FULL presents column 0; DRAIN covers columns 1..3.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      BANK_FILL: begin
        if (wr_en) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST_COL) begin
            state_d     = BANK_FULL;
            drain_cnt_d = FIRST_COL;
          end
        end
      end
      BANK_FULL: begin
        if (rd_en) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          state_d     = BANK_DRAIN;
        end
      end
      BANK_DRAIN: begin
        if (rd_en) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == LAST_COL) begin
            state_d    = BANK_FILL;
            fill_cnt_d = FIRST_COL;
          end
        end
      end
      default: begin
        state_d     = BANK_FILL;
        fill_cnt_d  = FIRST_COL;
        drain_cnt_d = FIRST_COL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BANK_FILL;
      fill_cnt_q  <= FIRST_COL;
      drain_cnt_q <= FIRST_COL;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    buf_d = buf_q;
    if (wr_en && (state_q == BANK_FILL)) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        buf_d[byte_idx(int'(fill_cnt_q), r)*BYTE_W +: BYTE_W] = wr_data[r*BYTE_W +: BYTE_W];
      end
    end
  end

  // Data storage carries no reset; validity is tracked by the control state.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      rd_data[r*BYTE_W +: BYTE_W] =
        buf_q[byte_idx(src_col(int'(drain_cnt_q), r, sel_inv), r)*BYTE_W +: BYTE_W];
    end
  end

  assign is_fill  = (state_q == BANK_FILL);
  assign has_data = (state_q == BANK_FULL) || (state_q == BANK_DRAIN);
  assign wr_last  = (fill_cnt_q == LAST_COL);
  assign rd_last  = (state_q == BANK_DRAIN) && (drain_cnt_q == LAST_COL);

endmodule
`default_nettype wire

// File: rtl/shift_rows_serial.sv
`default_nettype none
// ------------------------------------------------------------------------
// shift_rows_serial -- column-serial AES ShiftRows with BANKS ping-pong buffers
// Rev 1.0  (define SHIFT_ROWS_SERIAL_INV_EN for the inv port / inverse mapping)
// ------------------------------------------------------------------------
module shift_rows_serial
  import shift_rows_serial_pkg::*;
#(
  parameter int BANKS = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_ROWS_SERIAL_INV_EN
  input  logic             inv,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COL_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_data,
  output logic             out_last
);

  logic [BANKS-1:0] bank_fill;
  logic [BANKS-1:0] bank_has_data;
  logic [BANKS-1:0] bank_wr_last;
  logic [BANKS-1:0] bank_rd_last;
  logic [BANKS-1:0] bank_wr_en;
  logic [BANKS-1:0] bank_rd_en;
  logic [COL_W-1:0] bank_rd_data [BANKS];

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             in_fire, out_fire;
  logic             sel_fill, sel_wr_last, sel_has_data, sel_rd_last;
  logic [COL_W-1:0] sel_rd_data;

  genvar g;
  generate
    for (g = 0; g < BANKS; g++) begin : g_bank
      assign bank_wr_en[g] = in_fire  && (wr_ptr_q == 1'(g));
      assign bank_rd_en[g] = out_fire && (rd_ptr_q == 1'(g));

      shift_rows_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bank_wr_en[g]),
        .wr_data  (in_data),
`ifdef SHIFT_ROWS_SERIAL_INV_EN
        .wr_inv   (inv),
`endif
        .rd_en    (bank_rd_en[g]),
        .is_fill  (bank_fill[g]),
        .has_data (bank_has_data[g]),
        .wr_last  (bank_wr_last[g]),
        .rd_last  (bank_rd_last[g]),
        .rd_data  (bank_rd_data[g])
      );
    end
  endgenerate

  always_comb begin
    sel_fill     = 1'b0;
    sel_wr_last  = 1'b0;
    sel_has_data = 1'b0;
    sel_rd_last  = 1'b0;
    sel_rd_data  = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (wr_ptr_q == 1'(b)) begin
        sel_fill    = bank_fill[b];
        sel_wr_last = bank_wr_last[b];
      end
      if (rd_ptr_q == 1'(b)) begin
        sel_has_data = bank_has_data[b];
        sel_rd_last  = bank_rd_last[b];
        sel_rd_data  = bank_rd_data[b];
      end
    end
  end

  // Strict alternation keeps the write bank the oldest free one, so its FILL
  // flag alone tells whether any bank can take a beat.
  assign in_ready  = sel_fill;
  assign out_valid = sel_has_data;
  assign out_last  = sel_has_data & sel_rd_last;
  assign out_data  = sel_has_data ? sel_rd_data : '0;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (BANKS > 1) begin
      if (in_fire && sel_wr_last) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (out_fire && sel_rd_last) begin
        rd_ptr_d = ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire
